// File: rtl/wb_pkg.sv
// Shared Wishbone initiator definitions: bus widths and FSM state encodings.
package wb_pkg;

    localparam int WB_DW   = 32;
    localparam int WB_AW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating ack-wait counter; expired flags the edge on which the wait limit is reached.
module wb_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] MAX  = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of ack-less edges already seen, so the
    // TIMEOUT_CYCLES-th edge is the one taken while count sits at LAST.
    assign expired = (count == LAST) || (count == MAX);

endmodule

// File: rtl/wb_initiator.sv
// Single-beat Wishbone classic initiator bridging a valid/ready command port
// to a Wishbone responder and returning data or a timeout error.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WB_SELW-1:0] req_sel,
    input  logic [WB_AW-1:0]   req_adr,
    input  logic [WB_DW-1:0]   req_dat,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WB_DW-1:0]   rsp_dat,
    output logic               rsp_err,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic               wbm_we_o,
    output logic [WB_SELW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i
);

    wb_state_e state, state_nxt;
    logic      accept, done_ack, done_to;
    logic      expired;

    wb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (wb_clk_i),
        .reset  (wb_rst_i),
        .clear  (accept),
        .enable ((state == BUS) && !wbm_ack_i),
        .expired(expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ack is checked before expiry so a same-edge ack completes normally.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_ack  = 1'b0;
        done_to   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    state_nxt = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    done_ack  = 1'b1;
                    state_nxt = RESP;
                end else if (expired) begin
                    done_to   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and bus strobes are registered decodes of the next state,
    // so they change on the same edge as the state itself.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= (state_nxt == RESP);
            wbm_cyc_o <= (state_nxt == BUS);
            wbm_stb_o <= (state_nxt == BUS);

            if (accept) begin
                wbm_we_o  <= req_we;
                wbm_sel_o <= req_sel;
                wbm_adr_o <= req_adr;
                wbm_dat_o <= req_dat;
            end else if (done_ack || done_to) begin
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= '0;
                wbm_adr_o <= '0;
                wbm_dat_o <= '0;
            end

            if (done_ack) begin
                rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                rsp_err <= 1'b0;
            end else if (done_to) begin
                rsp_dat <= '0;
                rsp_err <= 1'b1;
            end
        end
    end

endmodule
